// File: rtl/pe_array_feeder.sv
// pe_array A-side feeder: reads a K-word tile from the input buffer,
// skews lane k by k cycles and drives srca_word/clear down the array.
`timescale 1ns/1ps

`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH (8*`DATA_WIDTH)
`endif
`ifndef DATA0
`define DATA0 (0*`DATA_WIDTH) +: `DATA_WIDTH
`define DATA1 (1*`DATA_WIDTH) +: `DATA_WIDTH
`define DATA2 (2*`DATA_WIDTH) +: `DATA_WIDTH
`define DATA3 (3*`DATA_WIDTH) +: `DATA_WIDTH
`define DATA4 (4*`DATA_WIDTH) +: `DATA_WIDTH
`define DATA5 (5*`DATA_WIDTH) +: `DATA_WIDTH
`define DATA6 (6*`DATA_WIDTH) +: `DATA_WIDTH
`define DATA7 (7*`DATA_WIDTH) +: `DATA_WIDTH
`endif

module pe_array_feeder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [ADDR_WIDTH-1:0]  base_addr_i,
  input  logic [LEN_WIDTH-1:0]   k_len_i,
  output logic                   rd_en_o,
  output logic [ADDR_WIDTH-1:0]  rd_addr_o,
  input  logic [`WORD_WIDTH-1:0] rd_data_i,
  output logic [`WORD_WIDTH-1:0] srca_word_o,
  output logic                   clear_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int DW = `DATA_WIDTH;
  localparam int NL = 8;
  // FLUSH spans K+1..K+10 relative to start: done in its last cycle
  localparam logic [3:0] FL_DONE = 4'd8;
  localparam logic [3:0] FL_LAST = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    FLUSH
  } state_t;

  state_t               state_q;
  logic [LEN_WIDTH-1:0] klen_q;
  logic [LEN_WIDTH-1:0] cnt_q;
  logic [3:0]           fcnt_q;
  logic                 vld1_q;
  logic                 vld2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      klen_q    <= '0;
      cnt_q     <= '0;
      fcnt_q    <= '0;
      rd_en_o   <= 1'b0;
      rd_addr_o <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            klen_q    <= k_len_i;
            cnt_q     <= '0;
            rd_en_o   <= 1'b1;
            rd_addr_o <= base_addr_i;
            busy_o    <= 1'b1;
            state_q   <= FEED;
          end
        end
        FEED: begin
          // compare against latched length so K=2^LEN_WIDTH cannot wrap
          if (cnt_q == klen_q) begin
            rd_en_o <= 1'b0;
            fcnt_q  <= '0;
            state_q <= FLUSH;
          end else begin
            cnt_q     <= cnt_q + 1'b1;
            rd_addr_o <= rd_addr_o + 1'b1;
          end
        end
        FLUSH: begin
          fcnt_q <= fcnt_q + 4'd1;
          if (fcnt_q == FL_DONE) done_o <= 1'b1;
          if (fcnt_q == FL_LAST) begin
            busy_o  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld1_q  <= 1'b0;
      vld2_q  <= 1'b0;
      clear_o <= 1'b0;
    end else begin
      vld1_q  <= rd_en_o;
      vld2_q  <= vld1_q;
      // falling edge of lane-0 validity
      clear_o <= vld2_q & ~vld1_q;
    end
  end

  for (genvar k = 0; k < NL; k++) begin : g_lane
    logic [DW-1:0] sr_q [0:k];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int j = 0; j <= k; j++) sr_q[j] <= '0;
      end else begin
        sr_q[0] <= vld1_q ? rd_data_i[k*DW +: DW] : '0;
        for (int j = 1; j <= k; j++) sr_q[j] <= sr_q[j-1];
      end
    end

    assign srca_word_o[k*DW +: DW] = sr_q[k];
  end

endmodule

// File: tb/tb_pe_array_feeder.sv
// Scoreboard bench for pe_array_feeder: per-cycle expectations
// are queued at each tile start and popped by a cycle monitor.
`timescale 1ns/1ps

`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH (8*`DATA_WIDTH)
`endif
`ifndef DATA3
`define DATA3 (3*`DATA_WIDTH) +: `DATA_WIDTH
`endif

module tb_pe_array_feeder;

  localparam int DW = `DATA_WIDTH;
  localparam int WW = `WORD_WIDTH;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic [9:0]    base_addr_i;
  logic [7:0]    k_len_i;
  logic          rd_en_o;
  logic [9:0]    rd_addr_o;
  logic [WW-1:0] rd_data_i;
  logic [WW-1:0] srca_word_o;
  logic          clear_o;
  logic          busy_o;
  logic          done_o;

  pe_array_feeder #(
    .ADDR_WIDTH(10),
    .LEN_WIDTH (8)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .base_addr_i(base_addr_i),
    .k_len_i    (k_len_i),
    .rd_en_o    (rd_en_o),
    .rd_addr_o  (rd_addr_o),
    .rd_data_i  (rd_data_i),
    .srca_word_o(srca_word_o),
    .clear_o    (clear_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int            cyc;
    logic          rd_en;
    logic [9:0]    addr;
    logic [WW-1:0] word;
    logic          clear;
    logic          done;
    logic          busy;
  } exp_t;

  exp_t       sb[$];
  exp_t       m_e;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         rd_cnt = 0;
  bit         mon_en = 1'b0;
  logic [9:0] cur_base = '0;

  task automatic check(input string tag,
                       input logic [WW-1:0] obs,
                       input logic [WW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // word i of a tile: lane j = i*16 + j
  function automatic logic [WW-1:0] tile_word(input logic [9:0] i);
    logic [WW-1:0] w;
    for (int j = 0; j < 8; j++)
      w[j*DW +: DW] = DW'(int'(i) * 16 + j);
    return w;
  endfunction

  always @(posedge clk_i) cyc <= cyc + 1;

  // buffer: 1-cycle read latency, garbage when not read
  always @(posedge clk_i) begin
    if (rd_en_o) rd_data_i <= tile_word(rd_addr_o - cur_base);
    else rd_data_i <= {$urandom, $urandom, $urandom, $urandom};
  end

  always @(posedge clk_i) begin
    #1;
    if (mon_en) begin
      m_e.cyc   = cyc;
      m_e.rd_en = 1'b0;
      m_e.addr  = '0;
      m_e.word  = '0;
      m_e.clear = 1'b0;
      m_e.done  = 1'b0;
      m_e.busy  = 1'b0;
      if (sb.size() != 0 && sb[0].cyc == cyc) m_e = sb.pop_front();
      check($sformatf("rd_en@%0d", cyc), WW'(rd_en_o), WW'(m_e.rd_en));
      if (m_e.rd_en)
        check($sformatf("addr@%0d", cyc), WW'(rd_addr_o), WW'(m_e.addr));
      check($sformatf("srca@%0d", cyc), srca_word_o, m_e.word);
      check($sformatf("clear@%0d", cyc), WW'(clear_o), WW'(m_e.clear));
      check($sformatf("done@%0d", cyc), WW'(done_o), WW'(m_e.done));
      check($sformatf("busy@%0d", cyc), WW'(busy_o), WW'(m_e.busy));
      if (rd_en_o) rd_cnt++;
    end
  end

  // call at a negedge; returns at the negedge of t0+1
  task automatic start_tile(input logic [9:0] base,
                            input int klen,
                            output int t0);
    exp_t          e;
    logic [WW-1:0] w;
    int            k;
    int            i;
    k           = klen + 1;
    t0          = cyc;
    start_i     = 1'b1;
    base_addr_i = base;
    k_len_i     = 8'(klen);
    cur_base    = base;
    for (int d = 1; d <= k + 10; d++) begin
      e.cyc   = t0 + d;
      e.rd_en = (d <= k);
      e.addr  = 10'(base + d - 1);
      e.word  = '0;
      for (int l = 0; l < 8; l++) begin
        i = d - 3 - l;
        if (i >= 0 && i < k) begin
          w = tile_word(10'(i));
          e.word[l*DW +: DW] = w[l*DW +: DW];
        end
      end
      e.clear = (d == k + 3);
      e.done  = (d == k + 10);
      e.busy  = 1'b1;
      sb.push_back(e);
    end
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  int t0;
  int t1;

  initial begin
    rst_ni      = 1'b0;
    start_i     = 1'b0;
    base_addr_i = '0;
    k_len_i     = '0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    mon_en = 1'b1;
    repeat (50) @(negedge clk_i);

    // K=4 tile with explicit lane-3 spot checks
    start_tile(10'h010, 3, t0);
    repeat (5) @(negedge clk_i);
    check("lane3_t0+6", WW'(srca_word_o[`DATA3]), WW'(16'h0003));
    repeat (3) @(negedge clk_i);
    check("lane3_t0+9", WW'(srca_word_o[`DATA3]), WW'(16'h0033));
    repeat (6) @(negedge clk_i);

    // minimum tile
    start_tile(10'h100, 0, t0);
    repeat (11) @(negedge clk_i);

    // address wrap with maximum length
    rd_cnt = 0;
    start_tile(10'h3FE, 255, t0);
    repeat (266) @(negedge clk_i);
    check("wrap_rd_cnt", WW'(rd_cnt), WW'(256));

    // start during FEED is ignored, then back-to-back start
    rd_cnt = 0;
    start_tile(10'h200, 5, t0);
    start_i     = 1'b1;
    base_addr_i = 10'h3F0;
    k_len_i     = 8'd0;
    @(negedge clk_i);
    start_i = 1'b0;
    while (cyc < t0 + 16) @(negedge clk_i);
    check("busy_rd_cnt", WW'(rd_cnt), WW'(6));
    @(negedge clk_i);
    start_tile(10'h050, 4, t1);
    check("b2b_t1", WW'(t1), WW'(t0 + 17));
    repeat (15) @(negedge clk_i);

    // asynchronous reset during FEED
    start_tile(10'h080, 7, t0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("rst_srca", srca_word_o, '0);
    check("rst_rd_en", WW'(rd_en_o), '0);
    check("rst_addr", WW'(rd_addr_o), '0);
    check("rst_clear", WW'(clear_o), '0);
    check("rst_busy", WW'(busy_o), '0);
    check("rst_done", WW'(done_o), '0);
    sb.delete();
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (30) @(negedge clk_i);

    start_tile(10'h300, 3, t0);
    repeat (15) @(negedge clk_i);

    check("sb_drain", WW'(sb.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_array_feeder.md
Name: pe_array_feeder

Overview:
- Source side of the pe_array A/clear interface.
- On start, reads a tile of K A-words (8 lanes x `DATA_WIDTH`, packed per `DATA0..`DATA7) from the input global buffer.
- Diagonally skews the lanes so lane k leaves k cycles after lane 0, matching the one-cycle-per-PE ripple of srcb and clear down a pe_array.
- Drives the head-of-chain srca_word and clear, and reports completion to the controller.

Parameters:
- ADDR_WIDTH, 10, input global buffer word-address width.
- LEN_WIDTH, 8, tile-length field width; K = k_len_i + 1, so K ranges 1..2^LEN_WIDTH.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- start_i  input  1  tile start request; sampled only in IDLE.
- base_addr_i  input  ADDR_WIDTH  first buffer address of the tile; sampled with start_i.
- k_len_i  input  LEN_WIDTH  tile length minus 1; sampled with start_i.
- rd_en_o  output  1  buffer read enable.
- rd_addr_o  output  ADDR_WIDTH  buffer read address.
- rd_data_i  input  `WORD_WIDTH  buffer read data, valid exactly 1 cycle after rd_en_o.
- srca_word_o  output  `WORD_WIDTH  skewed A word to pe_array srca_word_i.
- clear_o  output  1  clear pulse to pe_array clear_i.
- busy_o  output  1  high in FEED and FLUSH.
- done_o  output  1  one-cycle tile-complete pulse.

Behaviour:
- Reset (async, any state): state IDLE; all counters, skew registers and outputs cleared. srca_word_o=0, rd_en_o=0, rd_addr_o=0, clear_o=0, busy_o=0, done_o=0. An in-flight tile is abandoned; no done_o is issued for it.
- FSM states: IDLE, FEED, FLUSH.
- IDLE:
  - start_i=1 at cycle t0 latches base_addr_i and K.
  - Next state is FEED.
- FEED (cycles t0+1 .. t0+K):
  - rd_en_o=1; rd_addr_o = base + i for i = 0..K-1, computed modulo 2^ADDR_WIDTH (wrap allowed).
  - After K issues, next state is FLUSH.
- Data valid tracking:
  - A 1-cycle delayed copy of rd_en_o marks rd_data_i valid.
  - Invalid cycles inject all-zero lanes (bubbles contribute 0 to MACs).
- Skew datapath:
  - Lane 0 has one output register: lane-0 element i appears on srca_word_o[`DATA0] at cycle t0+3+i.
  - Lane k passes through k additional registers: element i appears at t0+3+i+k.
  - Outside its valid window, every lane outputs 0.
- clear_o:
  - Single-cycle pulse at t0+K+3, i.e. the cycle immediately after lane 0's last valid element.
  - The pe_array ripples it to lane 7 in step with the skew.
- FLUSH:
  - Waits for lane 7 to drain; its last element is at t0+K+9.
  - done_o=1 at t0+K+10; next state is IDLE.
- busy_o: 1 from t0+1 through t0+K+10 inclusive.
- start_i while busy: ignored; no queuing.
- Earliest back-to-back start: the cycle after done_o. Minimum tile period is K+11 cycles.
- K=1: a single read; clear_o at t0+4; done_o at t0+11.
- K=2^LEN_WIDTH: the read counter must not overflow early. The counter width is LEN_WIDTH+1, or it is compared against the latched k_len.
- Lane widths and packing are identical to the pe_array word layout; data is passed through unmodified (no arithmetic).

Test Plan:
- Reset then idle: hold rst_ni=0 then release, no start -> every output stays 0 for 50 cycles.
- Single tile: base=0x010, k_len=3 (K=4), buffer word i has lane j = 16'h(i*16+j).
  - rd_en_o high at t0+1..t0+4 with addr 0x010..0x013.
  - Lane 3 carries 0x0003, 0x0013, 0x0023, 0x0033 at t0+6..t0+9 and 0 otherwise.
  - clear_o at t0+7; done_o at t0+14.
- Minimum tile: k_len=0 -> one read; lane 7 nonzero only at t0+10; clear_o at t0+4; done_o at t0+11.
- Address wrap and maximum length: ADDR_WIDTH=10, base=0x3FE, k_len=255.
  - Addresses run 0x3FE, 0x3FF, 0x000, ... 0x0FD.
  - Exactly 256 rd_en_o cycles; done_o at t0+266.
- Start while busy plus back-to-back:
  - Pulse start_i during FEED -> ignored, read count unchanged.
  - Assert start_i the cycle after done_o -> new tile accepted; no zero-gap violation at lane 0.
- Reset mid-tile: drop rst_ni during FEED at i=2 of K=8.
  - All outputs 0 asynchronously; after release, no done_o and no clear_o occur.
  - A fresh start runs normally.
